// File: rtl/clk_div_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_mon_pkg
// Description : Shared types and default widths for the divided-clock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_mon_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_CNT_DEF    = 4;
    localparam int TIMEOUT_DEF     = 255;
    localparam int TOL_W           = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        ACQUIRE   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor_if
// Description : Config, divided-clock input and status bundle of the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_monitor_if
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             div_in;
    logic             enable;
    logic [CNT_W-1:0] exp_period;
    logic [TOL_W-1:0] period_tol;
    logic [TOL_W-1:0] duty_tol;
    logic             err_clr;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             locked;
    logic             err_period;
    logic             err_duty;
    logic             err_timeout;

    modport master (
        output div_in, enable, exp_period, period_tol, duty_tol, err_clr,
        input  meas_period, meas_high, meas_valid, locked,
               err_period, err_duty, err_timeout
    );

    modport slave (
        input  div_in, enable, exp_period, period_tol, duty_tol, err_clr,
        output meas_period, meas_high, meas_valid, locked,
               err_period, err_duty, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_monitor_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Multi-flop synchroniser for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor
// Description : Measures period/high time of a divided clock and checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    clk_div_monitor_if.slave mon
);
    localparam int               EW        = CNT_W + 2;
    localparam int               GC_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  C_LOCK    = GC_W'(LOCK_CNT);

    state_t           state_q;
    logic             s_d_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [GC_W-1:0]  good_cnt_q;
    logic [CNT_W-1:0] meas_period_q;
    logic [CNT_W-1:0] meas_high_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             err_period_q;
    logic             err_duty_q;
    logic             err_timeout_q;

    logic             w_s;
    logic             w_rise;
    logic [CNT_W-1:0] w_per_inc;
    logic [CNT_W-1:0] w_hi_inc;
    logic [GC_W-1:0]  w_gc_inc;
    logic [EW-1:0]    w_per_ext;
    logic [EW-1:0]    w_exp_ext;
    logic [EW-1:0]    w_two_hi;
    logic [EW-1:0]    w_dp;
    logic [EW-1:0]    w_dd;
    logic             w_good_p;
    logic             w_good_d;
    logic             w_good;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (mon.div_in),
        .q_o (w_s)
    );

    assign w_rise    = w_s & ~s_d_q;
    assign w_per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + C_ONE;
    assign w_hi_inc  = (w_s && (hi_cnt_q != '1)) ? hi_cnt_q + C_ONE : hi_cnt_q;
    assign w_gc_inc  = good_cnt_q + GC_W'(1);

    // Unsigned absolute differences, widened so 2*hi cannot overflow.
    assign w_per_ext = EW'(per_cnt_q);
    assign w_exp_ext = EW'(mon.exp_period);
    assign w_two_hi  = {1'b0, hi_cnt_q, 1'b0};
    assign w_dp      = (w_per_ext >= w_exp_ext) ? (w_per_ext - w_exp_ext) : (w_exp_ext - w_per_ext);
    assign w_dd      = (w_two_hi >= w_per_ext) ? (w_two_hi - w_per_ext) : (w_per_ext - w_two_hi);
    // A zero expectation is a deliberate "always fail" setting.
    assign w_good_p  = (mon.exp_period != '0) && (w_dp <= EW'(mon.period_tol));
    assign w_good_d  = (w_dd <= EW'(mon.duty_tol));
    assign w_good    = w_good_p & w_good_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            s_d_q         <= 1'b0;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            good_cnt_q    <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_period_q  <= 1'b0;
            err_duty_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            s_d_q        <= w_s;
            meas_valid_q <= 1'b0;
            // Clears come first so a same-cycle set below takes precedence.
            if (mon.err_clr) begin
                err_period_q  <= 1'b0;
                err_duty_q    <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            if (!mon.enable) begin
                state_q    <= IDLE;
                per_cnt_q  <= '0;
                hi_cnt_q   <= '0;
                good_cnt_q <= '0;
                locked_q   <= 1'b0;
            end else if (state_q == IDLE) begin
                state_q   <= WAIT_EDGE;
                per_cnt_q <= '0;
                hi_cnt_q  <= '0;
            end else if (w_rise) begin
                per_cnt_q <= C_ONE;
                hi_cnt_q  <= C_ONE;
                if (state_q == WAIT_EDGE) begin
                    state_q    <= ACQUIRE;
                    good_cnt_q <= '0;
                end else begin
                    meas_period_q <= per_cnt_q;
                    meas_high_q   <= hi_cnt_q;
                    meas_valid_q  <= 1'b1;
                    if (!w_good_p) begin
                        err_period_q <= 1'b1;
                    end
                    if (!w_good_d) begin
                        err_duty_q <= 1'b1;
                    end
                    if (!w_good) begin
                        state_q    <= ACQUIRE;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end else if (state_q == ACQUIRE) begin
                        if (w_gc_inc == C_LOCK) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= w_gc_inc;
                        end
                    end
                end
            end else if (per_cnt_q == C_TIMEOUT) begin
                // Restart the window so the timeout re-arms instead of firing every cycle.
                state_q       <= WAIT_EDGE;
                err_timeout_q <= 1'b1;
                locked_q      <= 1'b0;
                good_cnt_q    <= '0;
                per_cnt_q     <= '0;
                hi_cnt_q      <= '0;
            end else begin
                per_cnt_q <= w_per_inc;
                hi_cnt_q  <= w_hi_inc;
            end
        end
    end

    assign mon.meas_period = meas_period_q;
    assign mon.meas_high   = meas_high_q;
    assign mon.meas_valid  = meas_valid_q;
    assign mon.locked      = locked_q;
    assign mon.err_period  = err_period_q;
    assign mon.err_duty    = err_duty_q;
    assign mon.err_timeout = err_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Directed self-checking bench for clk_div_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_monitor;
    import clk_div_mon_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   n_valid;
    logic [7:0] cap_p;
    logic [7:0] cap_h;

    clk_div_monitor_if #(.CNT_W(8)) bus ();

    clk_div_monitor #(
        .CNT_W       (8),
        .SYNC_STAGES (2),
        .LOCK_CNT    (4),
        .TIMEOUT     (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One div_in period; err_clr is pulsed on tick index clr_at (the rise is acted on at index 2).
    task automatic drive_period(input int hi, input int lo, input int clr_at);
        for (int t = 0; t < hi + lo; t++) begin
            bus.div_in  = (t < hi);
            bus.err_clr = (t == clr_at);
            tick();
            if (bus.meas_valid) begin
                n_valid++;
                cap_p = bus.meas_period;
                cap_h = bus.meas_high;
            end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic hold_low(input int n);
        bus.div_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks       = 0;
        n_err          = 0;
        n_valid        = 0;
        cap_p          = '0;
        cap_h          = '0;
        rst            = 1'b1;
        bus.div_in     = 1'b0;
        bus.enable     = 1'b0;
        bus.exp_period = 8'd5;
        bus.period_tol = 4'd0;
        bus.duty_tol   = 4'd1;
        bus.err_clr    = 1'b0;
        tick();
        tick();
        chk("rst_meas_period", 32'(bus.meas_period), 32'd0);
        chk("rst_valid",       32'(bus.meas_valid),  32'd0);
        chk("rst_locked",      32'(bus.locked),      32'd0);
        chk("rst_errs",        32'({bus.err_period, bus.err_duty, bus.err_timeout}), 32'd0);
        chk("rst_state",       32'(dut.state_q),     32'(IDLE));

        // Test 1: div-by-5 wave, lock after four evaluated periods
        rst = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick();
        tick();
        chk("t1_wait_state", 32'(dut.state_q), 32'(WAIT_EDGE));
        for (int i = 0; i < 4; i++) drive_period(3, 2, -1);
        chk("t1_not_yet_locked", 32'(bus.locked), 32'd0);
        drive_period(3, 2, -1);
        chk("t1_locked",  32'(bus.locked), 32'd1);
        chk("t1_nvalid",  32'(n_valid),    32'd4);
        chk("t1_period",  32'(cap_p),      32'd5);
        chk("t1_high",    32'(cap_h),      32'd3);
        chk("t1_errs",    32'({bus.err_period, bus.err_duty, bus.err_timeout}), 32'd0);

        // Test 2: one period of 7 breaks lock, four good periods relock
        drive_period(3, 4, -1);
        chk("t2_still_locked", 32'(bus.locked), 32'd1);
        drive_period(3, 2, -1);
        chk("t2_period7",   32'(cap_p),          32'd7);
        chk("t2_err_per",   32'(bus.err_period), 32'd1);
        chk("t2_no_duty",   32'(bus.err_duty),   32'd0);
        chk("t2_unlocked",  32'(bus.locked),     32'd0);
        for (int i = 0; i < 3; i++) drive_period(3, 2, -1);
        chk("t2_relock_pending", 32'(bus.locked), 32'd0);
        drive_period(3, 2, -1);
        chk("t2_relocked", 32'(bus.locked), 32'd1);

        // Test 3: duty fault (6 period, 5 high), then err_clr
        bus.period_tol = 4'd1;
        bus.duty_tol   = 4'd2;
        drive_period(3, 2, 4);
        chk("t3_clr_period", 32'(bus.err_period), 32'd0);
        chk("t3_locked",     32'(bus.locked),     32'd1);
        drive_period(5, 1, -1);
        drive_period(3, 2, -1);
        chk("t3_meas_p",    32'(cap_p),          32'd6);
        chk("t3_meas_h",    32'(cap_h),          32'd5);
        chk("t3_err_duty",  32'(bus.err_duty),   32'd1);
        chk("t3_no_period", 32'(bus.err_period), 32'd0);
        chk("t3_unlocked",  32'(bus.locked),     32'd0);
        drive_period(3, 2, 4);
        chk("t3_clr_duty",  32'(bus.err_duty),   32'd0);

        // Test 6: err_clr in the same cycle as a bad-period set
        drive_period(3, 4, -1);
        drive_period(3, 2, 2);
        chk("t6_set_wins", 32'(bus.err_period), 32'd1);
        chk("t6_state",    32'(dut.state_q),    32'(ACQUIRE));

        // Test 4: timeout 255 cycles after the last rise (2 edges already elapsed)
        hold_low(252);
        chk("t4_before_timeout", 32'(bus.err_timeout), 32'd0);
        hold_low(1);
        chk("t4_timeout",  32'(bus.err_timeout), 32'd1);
        chk("t4_state",    32'(dut.state_q),     32'(WAIT_EDGE));
        chk("t4_unlocked", 32'(bus.locked),      32'd0);
        hold_low(47);

        // Test 5a: asynchronous reset mid-ACQUIRE
        drive_period(3, 2, -1);
        drive_period(3, 2, -1);
        chk("t5_pre_meas",  32'(bus.meas_period), 32'd5);
        chk("t5_pre_state", 32'(dut.state_q),     32'(ACQUIRE));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_meas",  32'(bus.meas_period), 32'd0);
        chk("t5_rst_high",  32'(bus.meas_high),   32'd0);
        chk("t5_rst_errs",  32'({bus.err_period, bus.err_duty, bus.err_timeout}), 32'd0);
        chk("t5_rst_state", 32'(dut.state_q),     32'(IDLE));
        rst = 1'b0;
        tick();

        // Test 5b: lock with a sticky error, then drop enable
        drive_period(3, 2, -1);
        drive_period(3, 4, -1);
        drive_period(3, 2, -1);
        chk("t5_err_period", 32'(bus.err_period), 32'd1);
        for (int i = 0; i < 3; i++) drive_period(3, 2, -1);
        chk("t5_not_locked", 32'(bus.locked), 32'd0);
        drive_period(3, 2, -1);
        chk("t5_locked", 32'(bus.locked), 32'd1);
        bus.enable = 1'b0;
        tick();
        chk("t5_en_unlock", 32'(bus.locked),     32'd0);
        chk("t5_en_sticky", 32'(bus.err_period), 32'd1);
        chk("t5_en_idle",   32'(dut.state_q),    32'(IDLE));

        // exp_period = 0 makes every evaluated period fail
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("z_cleared", 32'(bus.err_period), 32'd0);
        bus.exp_period = 8'd0;
        bus.enable     = 1'b1;
        tick();
        drive_period(3, 2, -1);
        drive_period(3, 2, -1);
        chk("z_err_period", 32'(bus.err_period), 32'd1);
        chk("z_no_duty",    32'(bus.err_duty),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
